branch_predictor: RTL and testbench

- Dual-slot branch predictor sitting upstream of the EX-stage branch unit, in the IF stage.
- For each fetch group of two instructions, slot A at `pc` and slot B at `pc+4`, it predicts taken / not-taken plus a target. The prediction travels down the pipe as the per-slot predict bits consumed by EX.
- EX resolution results come back on a single update port and train a direct-mapped BTB with 2-bit saturating counters.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dual-slot IF-stage branch predictor: direct-mapped BTB with 2-bit counters, one EX update port.
// Optional BP_PERF_EN adds perf_upd_cnt / perf_alloc_cnt performance counters.
module branch_predictor #(
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_W       = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        IF_valid,
  input  logic        IF_stall,
  input  logic [31:0] IF_pc,
  output logic        IF_pd_valid,
  output logic        IF_pd_a,
  output logic        IF_pd_b,
  output logic [31:0] IF_pd_target,
  input  logic        EX_upd_valid,
  input  logic [31:0] EX_upd_pc,
  input  logic        EX_upd_taken,
  input  logic [31:0] EX_upd_target
`ifdef BP_PERF_EN
  ,
  output logic [31:0] perf_upd_cnt,
  output logic [31:0] perf_alloc_cnt
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];
  logic [1:0]             cnt_q    [BTB_ENTRIES];

  logic [31:0]      pc_b;
  logic [IDX_W-1:0] idx_a, idx_b, idx_u;
  logic [TAG_W-1:0] tag_a, tag_b, tag_u;
  logic             taken_a, taken_b, hit_u;

  assign pc_b  = IF_pc + 32'd4;
  assign idx_a = IF_pc[IDX_W+1:2];
  assign idx_b = pc_b[IDX_W+1:2];
  assign idx_u = EX_upd_pc[IDX_W+1:2];
  assign tag_a = IF_pc[IDX_W+2 +: TAG_W];
  assign tag_b = pc_b[IDX_W+2 +: TAG_W];
  assign tag_u = EX_upd_pc[IDX_W+2 +: TAG_W];

  // Reads see the registered table, so a same-cycle update is invisible (read-before-write).
  assign taken_a = valid_q[idx_a] && (tag_q[idx_a] == tag_a) && cnt_q[idx_a][1];
  assign taken_b = valid_q[idx_b] && (tag_q[idx_b] == tag_b) && cnt_q[idx_b][1];
  assign hit_u   = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

  logic        pd_valid_d, pd_a_d, pd_b_d;
  logic [31:0] pd_target_d;
  logic        pd_valid_q, pd_a_q, pd_b_q;
  logic [31:0] pd_target_q;

  always_comb begin
    pd_valid_d  = pd_valid_q;
    pd_a_d      = pd_a_q;
    pd_b_d      = pd_b_q;
    pd_target_d = pd_target_q;
    if (!IF_stall) begin
      pd_valid_d = IF_valid;
      pd_a_d     = IF_valid && taken_a;
      pd_b_d     = IF_valid && taken_b && !taken_a;
      if (IF_valid) begin
        if (taken_a)      pd_target_d = {target_q[idx_a], 2'b00};
        else if (taken_b) pd_target_d = {target_q[idx_b], 2'b00};
        else              pd_target_d = IF_pc + 32'd8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pd_valid_q  <= 1'b0;
      pd_a_q      <= 1'b0;
      pd_b_q      <= 1'b0;
      pd_target_q <= 32'd0;
    end else begin
      pd_valid_q  <= pd_valid_d;
      pd_a_q      <= pd_a_d;
      pd_b_q      <= pd_b_d;
      pd_target_q <= pd_target_d;
    end
  end

  // Table training is independent of IF_stall so no update is ever dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (EX_upd_valid) begin
      if (hit_u) begin
        if (EX_upd_taken) begin
          target_q[idx_u] <= EX_upd_target[31:2];
          if (cnt_q[idx_u] != 2'b11) cnt_q[idx_u] <= cnt_q[idx_u] + 2'b01;
        end else if (cnt_q[idx_u] != 2'b00) begin
          cnt_q[idx_u] <= cnt_q[idx_u] - 2'b01;
        end
      end else if (EX_upd_taken) begin
        valid_q[idx_u]  <= 1'b1;
        tag_q[idx_u]    <= tag_u;
        target_q[idx_u] <= EX_upd_target[31:2];
        cnt_q[idx_u]    <= 2'b10;
      end
    end
  end

  assign IF_pd_valid  = pd_valid_q;
  assign IF_pd_a      = pd_a_q;
  assign IF_pd_b      = pd_b_q;
  assign IF_pd_target = pd_target_q;

`ifdef BP_PERF_EN
  logic [31:0] perf_upd_q, perf_alloc_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_upd_q   <= 32'd0;
      perf_alloc_q <= 32'd0;
    end else if (EX_upd_valid) begin
      perf_upd_q <= perf_upd_q + 32'd1;
      if (!hit_u && EX_upd_taken) perf_alloc_q <= perf_alloc_q + 32'd1;
    end
  end

  assign perf_upd_cnt   = perf_upd_q;
  assign perf_alloc_cnt = perf_alloc_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed vectors checked with immediate assertions.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        IF_valid, IF_stall;
  logic [31:0] IF_pc;
  logic        IF_pd_valid, IF_pd_a, IF_pd_b;
  logic [31:0] IF_pd_target;
  logic        EX_upd_valid, EX_upd_taken;
  logic [31:0] EX_upd_pc, EX_upd_target;
`ifdef BP_PERF_EN
  logic [31:0] perf_upd_cnt, perf_alloc_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rstn          (rstn),
    .IF_valid      (IF_valid),
    .IF_stall      (IF_stall),
    .IF_pc         (IF_pc),
    .IF_pd_valid   (IF_pd_valid),
    .IF_pd_a       (IF_pd_a),
    .IF_pd_b       (IF_pd_b),
    .IF_pd_target  (IF_pd_target),
    .EX_upd_valid  (EX_upd_valid),
    .EX_upd_pc     (EX_upd_pc),
    .EX_upd_taken  (EX_upd_taken),
    .EX_upd_target (EX_upd_target)
`ifdef BP_PERF_EN
    ,
    .perf_upd_cnt  (perf_upd_cnt),
    .perf_alloc_cnt(perf_alloc_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_valid = 1'b0; IF_stall = 1'b0; IF_pc = 32'd0;
    EX_upd_valid = 1'b0; EX_upd_taken = 1'b0; EX_upd_pc = 32'd0; EX_upd_target = 32'd0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    EX_upd_valid = 1'b1; EX_upd_pc = pc; EX_upd_taken = taken; EX_upd_target = tgt;
    tick();
    EX_upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    IF_valid = 1'b1; IF_pc = pc;
    tick();
    IF_valid = 1'b0;
  endtask

  task automatic expect_pd(input string tag, input logic v, input logic a, input logic b,
                           input logic [31:0] tgt);
    check({tag, ".valid"},  {31'd0, IF_pd_valid}, {31'd0, v});
    check({tag, ".a"},      {31'd0, IF_pd_a},     {31'd0, a});
    check({tag, ".b"},      {31'd0, IF_pd_b},     {31'd0, b});
    check({tag, ".target"}, IF_pd_target,         tgt);
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    tick(); tick();
    expect_pd("reset", 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef BP_PERF_EN
    check("perf_upd_reset",   perf_upd_cnt,   32'd0);
    check("perf_alloc_reset", perf_alloc_cnt, 32'd0);
`endif
    rstn = 1'b1;

    // Cold lookup
    lookup(32'h1C00_0000);
    expect_pd("cold", 1'b1, 1'b0, 1'b0, 32'h1C00_0008);

    // Allocate slot B (cnt=10) then hit
    upd(32'h1C00_0004, 1'b1, 32'h1C00_0100);
    lookup(32'h1C00_0000);
    expect_pd("alloc_hit", 1'b1, 1'b0, 1'b1, 32'h1C00_0100);

    // Counter training: 10->01->00 not taken, then ->11 and back to 10 still taken
    upd(32'h1C00_0004, 1'b0, 32'd0);
    upd(32'h1C00_0004, 1'b0, 32'd0);
    lookup(32'h1C00_0000);
    expect_pd("cnt00", 1'b1, 1'b0, 1'b0, 32'h1C00_0008);
    upd(32'h1C00_0004, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0004, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0004, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0004, 1'b0, 32'd0);
    lookup(32'h1C00_0000);
    expect_pd("cnt10", 1'b1, 1'b0, 1'b1, 32'h1C00_0100);

    // Both slots taken: A wins, B suppressed
    upd(32'h1C00_0000, 1'b1, 32'h1C00_0200);
    upd(32'h1C00_0004, 1'b1, 32'h1C00_0300);
    lookup(32'h1C00_0000);
    expect_pd("both", 1'b1, 1'b1, 1'b0, 32'h1C00_0200);

    // Same-cycle lookup and update to one index: old contents, then hit
    IF_valid = 1'b1; IF_pc = 32'h1C00_0010;
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0400);
    expect_pd("rbw_old", 1'b1, 1'b0, 1'b0, 32'h1C00_0018);
    lookup(32'h1C00_0010);
    expect_pd("rbw_new", 1'b1, 1'b1, 1'b0, 32'h1C00_0400);

    // Stall three cycles with a new lookup pending and an update landing
    IF_stall = 1'b1; IF_valid = 1'b1; IF_pc = 32'h1C00_0000;
    EX_upd_valid = 1'b1; EX_upd_pc = 32'h1C00_0020; EX_upd_taken = 1'b1;
    EX_upd_target = 32'h1C00_0500;
    tick();
    EX_upd_valid = 1'b0;
    expect_pd("stall1", 1'b1, 1'b1, 1'b0, 32'h1C00_0400);
    tick();
    expect_pd("stall2", 1'b1, 1'b1, 1'b0, 32'h1C00_0400);
    IF_valid = 1'b0;
    tick();
    expect_pd("stall3", 1'b1, 1'b1, 1'b0, 32'h1C00_0400);
    IF_stall = 1'b0;
    lookup(32'h1C00_0020);
    expect_pd("stall_upd", 1'b1, 1'b1, 1'b0, 32'h1C00_0500);

    // No lookup: valid/a/b drop, target holds
    tick();
    expect_pd("no_lookup", 1'b0, 1'b0, 1'b0, 32'h1C00_0500);

    // Alias: same index 0, tag 1 evicts slot A's entry
    upd(32'h1C00_0100, 1'b1, 32'h1C00_0600);
    lookup(32'h1C00_0000);
    expect_pd("alias_old", 1'b1, 1'b0, 1'b1, 32'h1C00_0300);
    lookup(32'h1C00_0100);
    expect_pd("alias_new", 1'b1, 1'b1, 1'b0, 32'h1C00_0600);

    // Mid-run reset with a pending update and a lookup: all discarded
    rstn = 1'b0;
    IF_valid = 1'b1; IF_pc = 32'h1C00_0100;
    EX_upd_valid = 1'b1; EX_upd_pc = 32'h1C00_0040; EX_upd_taken = 1'b1;
    EX_upd_target = 32'h1C00_0700;
    tick();
    idle();
    rstn = 1'b1;
    expect_pd("reset2", 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef BP_PERF_EN
    check("perf_upd_reset2",   perf_upd_cnt,   32'd0);
    check("perf_alloc_reset2", perf_alloc_cnt, 32'd0);
`endif
    lookup(32'h1C00_0000);
    expect_pd("post_rst_0", 1'b1, 1'b0, 1'b0, 32'h1C00_0008);
    lookup(32'h1C00_0020);
    expect_pd("post_rst_20", 1'b1, 1'b0, 1'b0, 32'h1C00_0028);
    lookup(32'h1C00_0040);
    expect_pd("post_rst_40", 1'b1, 1'b0, 1'b0, 32'h1C00_0048);
    lookup(32'h1C00_0100);
    expect_pd("post_rst_100", 1'b1, 1'b0, 1'b0, 32'h1C00_0108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
